// File: rtl/regfile_sb_if.sv
// Register-file port bundle: two writeback ports, NRP read ports, scoreboard set, busy count.
// master drives the writes, reads and scoreboard set; slave is the register file.
interface regfile_sb_if #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRP  = 2,
  parameter int CW   = $clog2(NREG + 1)
);
  logic              we0;
  logic [AW-1:0]     waddr0;
  logic [DW-1:0]     wdata0;
  logic              we1;
  logic [AW-1:0]     waddr1;
  logic [DW-1:0]     wdata1;
  logic [NRP-1:0]    re;
  logic [NRP*AW-1:0] raddr;
  logic [NRP*DW-1:0] rdata;
  logic [NRP-1:0]    rbusy;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic [CW-1:0]     busy_cnt;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, sb_set, sb_addr,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, sb_set, sb_addr,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-write / NRP-read register file with same-cycle write bypass and a pending-write scoreboard.
// Reads are combinational, writes and busy bits land on the next edge; no backpressure, every input sampled each cycle.
module regfile_sb #(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NRP    = 2,
  parameter int R0ZERO = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  rf
);
  localparam int CW = $clog2(NREG + 1);
  localparam bit R0 = (R0ZERO != 0);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_nxt;
  logic            wr0;
  logic            wr1;

  assign wr0 = rf.we0 && !(R0 && rf.waddr0 == '0);
  assign wr1 = rf.we1 && !(R0 && rf.waddr1 == '0);

  // Clears go in first so a same-cycle sb_set to that register supersedes them.
  always_comb begin
    busy_nxt = busy_q;
    if (rf.we0) busy_nxt[rf.waddr0] = 1'b0;
    if (rf.we1) busy_nxt[rf.waddr1] = 1'b0;
    if (rf.sb_set && !(R0 && rf.sb_addr == '0)) busy_nxt[rf.sb_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr0) regs[rf.waddr0] <= rf.wdata0;
      // Port 1 (load return) is written last so it wins an address collision.
      if (wr1) regs[rf.waddr1] <= rf.wdata1;
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign rf.busy_cnt = cnt_q;

  always_comb begin
    logic [AW-1:0] a;
    a        = '0;
    rf.rdata = '0;
    rf.rbusy = '0;
    for (int k = 0; k < NRP; k++) begin
      a = rf.raddr[k*AW +: AW];
      if (rst || !rf.re[k]) begin
        rf.rdata[k*DW +: DW] = '0;
      end else if (R0 && a == '0) begin
        rf.rdata[k*DW +: DW] = '0;
      end else if (rf.we1 && rf.waddr1 == a) begin
        rf.rdata[k*DW +: DW] = rf.wdata1;
      end else if (rf.we0 && rf.waddr0 == a) begin
        rf.rdata[k*DW +: DW] = rf.wdata0;
      end else begin
        rf.rdata[k*DW +: DW] = regs[a];
        rf.rbusy[k]          = busy_q[a];
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table against the default register file, then a 64-bit/16-entry/4-port instance under random traffic.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DW(32), .NREG(32), .NRP(2)) ifa ();
  regfile_sb_if #(.DW(64), .NREG(16), .NRP(4)) ifb ();

  regfile_sb #(.DW(32), .NREG(32), .NRP(2), .R0ZERO(1)) dut_a (.clk(clk), .rst(rst_a), .rf(ifa.slave));
  regfile_sb #(.DW(64), .NREG(16), .NRP(4), .R0ZERO(0)) dut_b (.clk(clk), .rst(rst_b), .rf(ifb.slave));

  typedef struct {
    logic        rst;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        sb;
    logic [4:0]  sa;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic we0, logic [4:0] wa0, logic [31:0] wd0,
                              logic we1, logic [4:0] wa1, logic [31:0] wd1,
                              logic [1:0] re, logic [4:0] ra0, logic [4:0] ra1,
                              logic sb, logic [4:0] sa,
                              logic [31:0] e0, logic [31:0] e1, logic [1:0] eb, logic [5:0] ec);
    vec_t v;
    v.rst = r;  v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.re = re;  v.ra0 = ra0; v.ra1 = ra1; v.sb = sb; v.sa = sa;
    v.e0 = e0;  v.e1 = e1;   v.eb = eb;   v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference state for the wide instance.
  logic [63:0] mregs [16];
  logic        mbusy [16];

  task automatic drive_b(input logic r, input logic we0, input logic [3:0] wa0, input logic [63:0] wd0,
                         input logic we1, input logic [3:0] wa1, input logic [63:0] wd1,
                         input logic [3:0] re, input logic [15:0] ra,
                         input logic sb, input logic [3:0] sa);
    logic [63:0] ed;
    logic        eb;
    logic [3:0]  a;
    int          cnt;
    rst_b = r;
    ifb.we0 = we0; ifb.waddr0 = wa0; ifb.wdata0 = wd0;
    ifb.we1 = we1; ifb.waddr1 = wa1; ifb.wdata1 = wd1;
    ifb.re = re; ifb.raddr = ra; ifb.sb_set = sb; ifb.sb_addr = sa;
    #2;
    cnt = 0;
    for (int i = 0; i < 16; i++) if (mbusy[i]) cnt++;
    chk("b_busy_cnt", 64'(ifb.busy_cnt), 64'(cnt));
    for (int k = 0; k < 4; k++) begin
      a  = ra[k*4 +: 4];
      ed = '0;
      eb = 1'b0;
      if (r || !re[k]) begin
        ed = '0;
      end else if (we1 && wa1 == a) begin
        ed = wd1;
      end else if (we0 && wa0 == a) begin
        ed = wd0;
      end else begin
        ed = mregs[a];
        eb = mbusy[a];
      end
      chk($sformatf("b_rdata%0d", k), ifb.rdata[k*64 +: 64], ed);
      chk($sformatf("b_rbusy%0d", k), 64'(ifb.rbusy[k]), 64'(eb));
    end
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        mregs[i] = '0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (we0) begin mregs[wa0] = wd0; mbusy[wa0] = 1'b0; end
      if (we1) begin mregs[wa1] = wd1; mbusy[wa1] = 1'b0; end
      if (sb) mbusy[sa] = 1'b1;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.we0 = 0; ifa.waddr0 = 0; ifa.wdata0 = 0; ifa.we1 = 0; ifa.waddr1 = 0; ifa.wdata1 = 0;
    ifa.re = 0; ifa.raddr = 0; ifa.sb_set = 0; ifa.sb_addr = 0;
    ifb.we0 = 0; ifb.waddr0 = 0; ifb.wdata0 = 0; ifb.we1 = 0; ifb.waddr1 = 0; ifb.wdata1 = 0;
    ifb.re = 0; ifb.raddr = 0; ifb.sb_set = 0; ifb.sb_addr = 0;
    for (int i = 0; i < 16; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end

    vt.push_back(mk(0,1, 5,32'h1234,    0,0,0,        3, 5, 5, 0,0, 32'h1234,    32'h1234,    2'b00,0));
    vt.push_back(mk(1,1, 6,32'h99,      0,0,0,        3, 5, 5, 1,8, 0,           0,           2'b00,0));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 5, 6, 0,0, 0,           0,           2'b00,0));
    vt.push_back(mk(0,1, 3,32'hA5A5A5A5,0,0,0,        3, 3, 0, 0,0, 32'hA5A5A5A5,0,           2'b00,0));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 3, 3, 0,0, 32'hA5A5A5A5,32'hA5A5A5A5,2'b00,0));
    vt.push_back(mk(0,1, 7,32'h11,      1,7,32'h22,   3, 7, 3, 0,0, 32'h22,      32'hA5A5A5A5,2'b00,0));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 7, 7, 0,0, 32'h22,      32'h22,      2'b00,0));
    vt.push_back(mk(0,1, 0,32'hFFFF,    0,0,0,        3, 0, 0, 1,0, 0,           0,           2'b00,0));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 0, 7, 0,0, 0,           32'h22,      2'b00,0));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 9, 9, 1,9, 0,           0,           2'b00,0));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 9, 3, 0,0, 0,           32'hA5A5A5A5,2'b01,1));
    vt.push_back(mk(0,0, 0,0,           1,9,32'h55,   3, 9, 9, 0,0, 32'h55,      32'h55,      2'b00,1));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 9, 9, 0,0, 32'h55,      32'h55,      2'b00,0));
    vt.push_back(mk(0,1, 9,32'h66,      0,0,0,        3, 9, 9, 1,9, 32'h66,      32'h66,      2'b00,0));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 9, 9, 0,0, 32'h66,      32'h66,      2'b11,1));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        1, 9, 9, 1,9, 32'h66,      0,           2'b01,1));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 9,10, 1,10,32'h66,      0,           2'b01,1));
    vt.push_back(mk(0,1,10,32'h77,      0,0,0,        3, 9,10, 0,0, 32'h66,      32'h77,      2'b01,2));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3,10, 9, 0,0, 32'h77,      32'h66,      2'b10,1));
    vt.push_back(mk(0,1, 9,32'hAB,      1,9,32'hCD,   3, 9, 1, 0,0, 32'hCD,      0,           2'b00,1));
    vt.push_back(mk(0,0, 0,0,           0,0,0,        3, 9, 9, 0,0, 32'hCD,      32'hCD,      2'b00,0));

    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;

    for (int n = 0; n < vt.size(); n++) begin
      @(negedge clk);
      rst_a = vt[n].rst;
      ifa.we0 = vt[n].we0; ifa.waddr0 = vt[n].wa0; ifa.wdata0 = vt[n].wd0;
      ifa.we1 = vt[n].we1; ifa.waddr1 = vt[n].wa1; ifa.wdata1 = vt[n].wd1;
      ifa.re = vt[n].re; ifa.raddr = {vt[n].ra1, vt[n].ra0};
      ifa.sb_set = vt[n].sb; ifa.sb_addr = vt[n].sa;
      #2;
      chk($sformatf("a_rdata0[%0d]", n),  64'(ifa.rdata[31:0]),  64'(vt[n].e0));
      chk($sformatf("a_rdata1[%0d]", n),  64'(ifa.rdata[63:32]), 64'(vt[n].e1));
      chk($sformatf("a_rbusy[%0d]", n),   64'(ifa.rbusy),        64'(vt[n].eb));
      chk($sformatf("a_busy_cnt[%0d]", n),64'(ifa.busy_cnt),     64'(vt[n].ec));
    end

    // Wide instance: r0 is an ordinary register here, then random traffic.
    @(negedge clk);
    drive_b(1, 0,0,0, 0,0,0, 4'hF, 16'h0000, 0,0);
    @(negedge clk);
    drive_b(0, 1,0,64'hDEAD_BEEF_0000_0001, 0,0,0, 4'hF, 16'h0000, 1,0);
    @(negedge clk);
    drive_b(0, 0,0,0, 0,0,0, 4'hF, 16'h3210, 0,0);
    @(negedge clk);
    drive_b(0, 0,0,0, 1,0,64'h0123_4567_89AB_CDEF, 4'hB, 16'h0000, 0,0);
    @(negedge clk);
    drive_b(0, 0,0,0, 0,0,0, 4'hF, 16'h0000, 0,0);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive_b($urandom_range(0, 63) == 0,
              1'($urandom), 4'($urandom), {$urandom, $urandom},
              1'($urandom), 4'($urandom), {$urandom, $urandom},
              4'($urandom), 16'($urandom),
              1'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
